// File: rtl/ram8_bank.sv
// Eight-word x WIDTH-bit RAM. Each storage bit is a reset-able DFF fed by a
// 2:1 select (held value vs. write data); reads are purely combinational.

module ram8_bit (
    input  logic clk,
    input  logic reset,
    input  logic d,
    input  logic load,
    output logic q
);
    logic nxt;

    // Select-then-DFF cell: matches the existing gate library mapping.
    assign nxt = load ? d : q;

    always_ff @(posedge clk) begin
        if (reset) q <= 1'b0;
        else       q <= nxt;
    end
endmodule

module ram8_bank #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    input  logic [2:0]       address,
    output logic [WIDTH-1:0] out
);
    logic [7:0]            word_load;
    logic [7:0][WIDTH-1:0] word_q;

    // One-hot load demux: at most one word sees load per cycle.
    always_comb begin
        word_load          = '0;
        word_load[address] = load;
    end

    for (genvar w = 0; w < 8; w++) begin : g_word
        for (genvar b = 0; b < WIDTH; b++) begin : g_bit
            ram8_bit u_bit (
                .clk  (clk),
                .reset(reset),
                .d    (in[b]),
                .load (word_load[w]),
                .q    (word_q[w][b])
            );
        end
    end

    // No write-through: out shows the stored word until the write edge.
    assign out = word_q[address];
endmodule

// File: tb/tb_ram8_bank.sv
// Directed self-checking bench for ram8_bank (WIDTH=16).

module tb_ram8_bank;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] in;
    logic        load;
    logic [2:0]  address;
    logic [15:0] out;

    int checks   = 0;
    int failures = 0;

    ram8_bank #(.WIDTH(16)) dut (
        .clk    (clk),
        .reset  (reset),
        .in     (in),
        .load   (load),
        .address(address),
        .out    (out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; load = 1'b0; in = 16'h1234; address = 3'd0;
        tick();
        reset = 1'b0;
        for (int a = 0; a < 8; a++) begin
            address = 3'(a);
            #1;
            checks++;
            if (out !== 16'h0000) begin
                failures++;
                $display("FAIL reset_read addr=%0d got=%h exp=0000", a, out);
            end
        end
    endtask

    task automatic test_write_all();
        for (int a = 0; a < 8; a++) begin
            address = 3'(a);
            in      = 16'(16'h1111 * a);
            load    = 1'b1;
            tick();
        end
        load = 1'b0;
        for (int a = 0; a < 8; a++) begin
            logic [15:0] exp;
            exp     = 16'(16'h1111 * a);
            address = 3'(a);
            #1;
            checks++;
            if (out !== exp) begin
                failures++;
                $display("FAIL write_all addr=%0d got=%h exp=%h", a, out, exp);
            end
        end
    endtask

    task automatic test_no_bypass();
        address = 3'd3; in = 16'hBEEF; load = 1'b1;
        #1;
        checks++;
        if (out !== 16'h3333) begin
            failures++;
            $display("FAIL no_bypass_pre got=%h exp=3333", out);
        end
        tick();
        load = 1'b0;
        checks++;
        if (out !== 16'hBEEF) begin
            failures++;
            $display("FAIL no_bypass_post got=%h exp=beef", out);
        end
        for (int a = 0; a < 8; a++) begin
            logic [15:0] exp;
            exp     = (a == 3) ? 16'hBEEF : 16'(16'h1111 * a);
            address = 3'(a);
            #1;
            checks++;
            if (out !== exp) begin
                failures++;
                $display("FAIL no_bypass_others addr=%0d got=%h exp=%h", a, out, exp);
            end
        end
    endtask

    task automatic test_hold();
        load = 1'b0; in = 16'hFFFF;
        for (int a = 0; a < 8; a++) begin
            logic [15:0] exp;
            address = 3'(7 - a);
            tick();
            exp = ((7 - a) == 3) ? 16'hBEEF : 16'(16'h1111 * (7 - a));
            checks++;
            if (out !== exp) begin
                failures++;
                $display("FAIL hold addr=%0d got=%h exp=%h", 7 - a, out, exp);
            end
        end
    endtask

    task automatic test_reset_priority();
        address = 3'd5; in = 16'hAAAA; load = 1'b1; reset = 1'b1;
        tick();
        reset = 1'b0; load = 1'b0;
        for (int a = 0; a < 8; a++) begin
            address = 3'(a);
            #1;
            checks++;
            if (out !== 16'h0000) begin
                failures++;
                $display("FAIL reset_over_load addr=%0d got=%h exp=0000", a, out);
            end
        end
        address = 3'd5; in = 16'hAAAA; load = 1'b1;
        tick();
        load = 1'b0;
        checks++;
        if (out !== 16'hAAAA) begin
            failures++;
            $display("FAIL write_after_reset got=%h exp=aaaa", out);
        end
        address = 3'd4;
        #1;
        checks++;
        if (out !== 16'h0000) begin
            failures++;
            $display("FAIL neighbour_after_reset got=%h exp=0000", out);
        end
    endtask

    task automatic test_boundary();
        address = 3'd7; in = 16'hFFFF; load = 1'b1;
        tick();
        address = 3'd0; in = 16'h8000;
        tick();
        load = 1'b0;
        address = 3'd7;
        #1;
        checks++;
        if (out !== 16'hFFFF) begin
            failures++;
            $display("FAIL word7_full got=%h exp=ffff", out);
        end
        address = 3'd0;
        #1;
        checks++;
        if (out !== 16'h8000) begin
            failures++;
            $display("FAIL word0_msb got=%h exp=8000", out);
        end
        address = 3'd6;
        #1;
        checks++;
        if (out !== 16'h0000) begin
            failures++;
            $display("FAIL word6_untouched got=%h exp=0000", out);
        end
        address = 3'd5;
        #1;
        checks++;
        if (out !== 16'hAAAA) begin
            failures++;
            $display("FAIL word5_kept got=%h exp=aaaa", out);
        end
    endtask

    initial begin
        reset = 1'b1; load = 1'b0; in = '0; address = '0;
        test_reset();
        test_write_all();
        test_no_bypass();
        test_hold();
        test_reset_priority();
        test_boundary();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
